// File: rtl/lfsr_random_server.sv
// -----------------------------------------------------------------------------
// lfsr_random_server
//
// Shares one Fibonacci LFSR among NUM_REQ requesters. A round-robin arbiter
// grants one requester at a time; each grant collects WORD_WIDTH successive
// LFSR output bits (LSB first) and returns them as one word with a one-cycle
// ack pulse. The LFSR free-runs in every state and can be reseeded or
// perturbed by an entropy bit. An all-zero LFSR state is reloaded with
// LFSR_INIT and reported with a one-cycle lockup pulse.
//
// Ports
//   clk_i          clock, rising edge
//   rst_n_i        asynchronous reset, active low
//   req_i          level request per requester, held until its ack
//   entropy_i      XORed into the feedback bit on every shift
//   seed_valid_i   load seed_data_i into the LFSR this cycle
//   seed_data_i    new LFSR state (zero is replaced by LFSR_INIT)
//   ack_o          one-hot, one-cycle pulse: rdata_o valid for that requester
//   rdata_o        delivered word, held until the next ack
//   gnt_id_o       index of the current / last grantee
//   busy_o         high while filling or delivering a word
//   lockup_o       one-cycle pulse after an all-zero state was reloaded
// -----------------------------------------------------------------------------
// state     | meaning
// ----------+-----------------------------------------------------------------
// S_IDLE    | no grant; arbitrate among pending requests
// S_FILL    | shifting LFSR output bits into the word for gnt_q
// S_DELIVER | present the word on rdata_o, pulse ack_o, advance rr pointer
// -----------------------------------------------------------------------------
module lfsr_random_server #(
    parameter int unsigned                  NUM_REQ       = 4,
    parameter int unsigned                  WORD_WIDTH    = 8,
    parameter int unsigned                  LFSR_WIDTH    = 16,
    parameter logic [LFSR_WIDTH-1:0]        LFSR_INIT     = 16'hACE1,
    parameter logic [LFSR_WIDTH-1:0]        LFSR_FEEDBACK = 16'h002D,
    localparam int unsigned                 ID_W          = $clog2(NUM_REQ),
    localparam int unsigned                 CNT_W         = $clog2(WORD_WIDTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [NUM_REQ-1:0]    req_i,
    input  logic                  entropy_i,
    input  logic                  seed_valid_i,
    input  logic [LFSR_WIDTH-1:0] seed_data_i,
    output logic [NUM_REQ-1:0]    ack_o,
    output logic [WORD_WIDTH-1:0] rdata_o,
    output logic [ID_W-1:0]       gnt_id_o,
    output logic                  busy_o,
    output logic                  lockup_o
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FILL    = 2'd1,
        S_DELIVER = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [LFSR_WIDTH-1:0]   shift_q, shift_d;
    logic                    lockup_q, lockup_d;
    logic [ID_W-1:0]         gnt_q, gnt_d;
    logic [ID_W-1:0]         rr_q, rr_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [WORD_WIDTH-1:0]   word_q, word_d;
    logic [WORD_WIDTH-1:0]   rdata_q, rdata_d;
    logic [NUM_REQ-1:0]      ack_q, ack_d;
    logic [ID_W-1:0]         pick;
    logic                    found;
    logic                    fb;
    logic [ID_W-1:0]         rr_next;

    // LFSR next state: seed beats lockup recovery beats normal shift.
    always_comb begin
        fb       = entropy_i ^ (^(shift_q & LFSR_FEEDBACK));
        lockup_d = 1'b0;
        if (seed_valid_i) begin
            shift_d = (seed_data_i == '0) ? LFSR_INIT : seed_data_i;
        end else if (shift_q == '0) begin
            shift_d  = LFSR_INIT;
            lockup_d = 1'b1;
        end else begin
            shift_d = {fb, shift_q[LFSR_WIDTH-1:1]};
        end
    end

    // Round-robin pick: first asserted request at or after rr_q, wrapping.
    always_comb begin
        int unsigned idx;
        pick  = rr_q;
        found = 1'b0;
        idx   = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = (32'(rr_q) + i) % NUM_REQ;
            if (!found && req_i[idx[ID_W-1:0]]) begin
                pick  = idx[ID_W-1:0];
                found = 1'b1;
            end
        end
    end

    assign rr_next = (gnt_q == ID_W'(NUM_REQ - 1)) ? '0 : gnt_q + ID_W'(1);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        rdata_d = rdata_q;
        ack_d   = '0;
        unique case (state_q)
            S_IDLE: begin
                if (|req_i) begin
                    gnt_d   = pick;
                    cnt_d   = '0;
                    state_d = S_FILL;
                end
            end
            S_FILL: begin
                if (!req_i[gnt_q]) begin
                    // Requester withdrew: drop partial word, keep rr pointer.
                    cnt_d   = '0;
                    word_d  = '0;
                    state_d = S_IDLE;
                end else begin
                    // Shift in from the top so the first bit ends at bit 0.
                    word_d = (word_q >> 1)
                           | (WORD_WIDTH'(shift_q[0]) << (WORD_WIDTH - 1));
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WORD_WIDTH - 1)) begin
                        state_d = S_DELIVER;
                    end
                end
            end
            S_DELIVER: begin
                rdata_d = word_q;
                ack_d   = NUM_REQ'(1) << gnt_q;
                rr_d    = rr_next;
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= S_IDLE;
            shift_q  <= LFSR_INIT;
            lockup_q <= 1'b0;
            gnt_q    <= '0;
            rr_q     <= '0;
            cnt_q    <= '0;
            word_q   <= '0;
            rdata_q  <= '0;
            ack_q    <= '0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            lockup_q <= lockup_d;
            gnt_q    <= gnt_d;
            rr_q     <= rr_d;
            cnt_q    <= cnt_d;
            word_q   <= word_d;
            rdata_q  <= rdata_d;
            ack_q    <= ack_d;
        end
    end

    assign ack_o    = ack_q;
    assign rdata_o  = rdata_q;
    assign gnt_id_o = gnt_q;
    assign busy_o   = (state_q != S_IDLE);
    assign lockup_o = lockup_q;

endmodule
